ifetch: RTL
===========

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter DEPTH, default 2, number of entries in the instruction buffer; the only legal values are 2 and 4.
REQ-003 i_clk  input  1  the block's single clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  reset, asynchronous and active-high.
REQ-005 o_imem_addr  output  32  instruction memory word index, {2'b00, pc[31:2]}.
REQ-006 i_imem_data  input  32  instruction word returned combinationally for o_imem_addr in the same cycle.
REQ-007 i_redirect  input  1  taken branch/jump; flushes the block and loads a new PC.
REQ-008 i_redirect_pc  input  32  byte target PC; sampled only when i_redirect=1.
REQ-009 o_inst_valid  output  1  the head buffer entry is presented to decode.
REQ-010 i_inst_ready  input  1  decode accepts the head entry this cycle.
REQ-011 o_inst  output  32  head entry instruction word.
REQ-012 o_inst_pc  output  32  head entry byte PC.
REQ-013 o_misalign  output  1  misaligned redirect flag; present only under IFETCH_MISALIGN_TRAP_EN.

Function
REQ-014 The block SHALL hold a 32-bit pc register that drives o_imem_addr combinationally.
REQ-015 pop SHALL be o_inst_valid & i_inst_ready.
REQ-016 push SHALL be !i_redirect & (count<DEPTH | pop); on push, {pc, i_imem_data} is written at the tail and pc <= pc+4.
REQ-017 pc SHALL advance modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-018 The buffer SHALL be a circular FIFO with head/tail pointers and count 0..DEPTH; o_inst_valid = (count!=0); o_inst and o_inst_pc come from the head entry.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including when the buffer is full.
REQ-020 No push SHALL occur while count==DEPTH and pop==0; pc holds and o_imem_addr is stable.
REQ-021 o_inst and o_inst_pc SHALL remain stable while o_inst_valid=1 and i_inst_ready=0.
REQ-022 On i_redirect=1, the next edge SHALL clear count and the pointers and load pc <= i_redirect_pc; no push occurs in that cycle.
REQ-023 A pop in the redirect cycle SHALL count as a completed transfer.
REQ-024 o_inst_valid SHALL be 0 in the cycle after a redirect; the target instruction is valid in the second cycle after the redirect.
REQ-025 Latency from address to o_inst_valid SHALL be 1 cycle; sustained throughput is 1 instruction/cycle while i_inst_ready=1.
REQ-026 Back-to-back redirects SHALL each take effect, and only the last target is fetched.

Reset
REQ-027 While i_rst=1: pc=RESET_PC, count=0, pointers=0, o_inst_valid=0, o_inst=32'h0000_0013 (NOP), o_inst_pc=RESET_PC, o_misalign=0.
REQ-028 Reset asserted mid-operation SHALL immediately discard all buffered entries, without waiting for a clock edge.
REQ-029 The first push SHALL occur on the first rising edge after i_rst deasserts; o_inst_valid=1 one cycle later.

Configuration
REQ-030 Macro IFETCH_MISALIGN_TRAP_EN selects misaligned-redirect trapping.
REQ-031 With IFETCH_MISALIGN_TRAP_EN defined: a redirect with i_redirect_pc[1:0]!=0 sets sticky o_misalign=1 and stops all pushes until reset or an aligned redirect; pc loads the target unmodified.
REQ-032 With IFETCH_MISALIGN_TRAP_EN undefined: the o_misalign port is absent, and i_redirect_pc[1:0] is forced to 0 when loaded into pc.

Verification
REQ-033 Streaming: reset with RESET_PC=0, i_inst_ready=1, memory word n = n -> o_inst = 0,1,2,3... with o_inst_pc = 0,4,8,12..., first valid in the 1st cycle after reset release, no bubbles.
REQ-034 Backpressure: i_inst_ready=0 for 5 cycles from the start -> count saturates at DEPTH, pc holds at 4*DEPTH, head stays pc 0; after release, entries drain in order with none lost or duplicated.
REQ-035 Redirect: redirect to 32'h100 while the buffer is full -> valid=0 for one cycle, then o_inst_pc=0x100, 0x104...; no stale entry appears.
REQ-036 Wrap: redirect to 32'hFFFF_FFF8 -> o_inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 Async reset pulse mid-stream (between edges) -> o_inst_valid drops immediately; restart from RESET_PC.
REQ-038 Misalign (IFETCH_MISALIGN_TRAP_EN defined): redirect to 32'h102 -> o_misalign=1 and no valid until a redirect to 32'h200, then o_inst_pc=0x200; with the macro undefined, the same redirect fetches pc 0x100.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch: PC register feeding a small circular instruction buffer toward decode.
// Optional IFETCH_MISALIGN_TRAP_EN: misaligned redirects set sticky o_misalign and halt fetch.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
`ifdef IFETCH_MISALIGN_TRAP_EN
    output logic [31:0] o_inst_pc,
    output logic        o_misalign
`else
    output logic [31:0] o_inst_pc
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    generate
        if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
            $error("ifetch: DEPTH must be 2 or 4");
        end
    endgenerate

    logic [31:0]      pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [31:0]      buf_inst [DEPTH];
    logic [31:0]      buf_pc   [DEPTH];

    logic        pop;
    logic        push;
    logic        fetch_en;
    logic [31:0] redirect_target;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic misalign;

    // Sticky until reset or an aligned redirect; clearing and setting share the redirect edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            misalign <= 1'b0;
        end else if (i_redirect) begin
            misalign <= |i_redirect_pc[1:0];
        end
    end

    assign o_misalign      = misalign;
    assign fetch_en        = !misalign;
    assign redirect_target = i_redirect_pc;
`else
    logic [1:0] unused_pc_bits;

    assign unused_pc_bits  = i_redirect_pc[1:0];
    assign fetch_en        = 1'b1;
    assign redirect_target = {i_redirect_pc[31:2], 2'b00};
`endif

    assign o_imem_addr  = {2'b00, pc[31:2]};
    assign o_inst_valid = (count != '0);
    assign o_inst       = buf_inst[head];
    assign o_inst_pc    = buf_pc[head];

    assign pop  = o_inst_valid & i_inst_ready;
    assign push = !i_redirect & fetch_en & ((count < FULL) | pop);

    // Buffer entries reset too so the head presents NOP/RESET_PC while held in reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_inst[i] <= NOP;
                buf_pc[i]   <= RESET_PC;
            end
        end else if (i_redirect) begin
            pc    <= redirect_target;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                buf_inst[tail] <= i_imem_data;
                buf_pc[tail]   <= pc;
                tail           <= tail + 1'b1;
                pc             <= pc + 32'd4;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
